turn_sequencer: RTL
===================

// Module: turn_sequencer
// PURPOSE
//   Game-flow controller that drives the turn-advance strobe into next_turn and
//   consumes its 2-bit turn index. For each resolved tile flip it either moves
//   the current player's chicken one step or ends the turn by pulsing the strobe.
//   It tracks all chicken positions, detects the winner and holds game over.
//   Sits between the tile-flip logic and next_turn, above the display path.
// PARAMETERS
//   POS_W       5   width of each player position counter
//   WIN_POS     23  position that wins the game (must be < 2**POS_W)
//   STROBE_CYC  2   cycles next_turn_strobe is held high per turn change (>=1)
//   SETTLE_CYC  1   cycles after strobe falls before turn is sampled (>=1)
// PORTS
//   clk               in   1        system clock, rising edge
//   rst               in   1        asynchronous, active-high reset
//   start             in   1        1-cycle pulse; begins a new game (IDLE/DONE only)
//   N                 in   2        player count code: 00=2, 01=3, 10=4, 11=invalid
//   turn              in   2        current player index from next_turn result
//   flip_valid        in   1        1-cycle pulse: a tile flip has been resolved
//   flip_match        in   1        flip result, qualified by flip_valid (1=match)
//   next_turn_strobe  out  1        turn-advance strobe to next_turn (rising edge = advance)
//   pos_all           out  4*POS_W  positions {p3,p2,p1,p0}, registered
//   cur_player        out  2        registered copy of turn, updated at turn change
//   ready             out  1        high only in WAIT_FLIP
//   game_over         out  1        high in DONE
//   winner            out  2        winning player index, valid while game_over=1
// BEHAVIOUR
//   Reset (async): state=IDLE; all outputs 0; strobe drops at once, mid-pulse too.
//   States: IDLE, WAIT_FLIP, ADVANCE, STROBE, SETTLE, DONE.
//   IDLE: start=1 and N!=11 -> latch N as n_code, clear pos_all, cur_player<=turn,
//     -> WAIT_FLIP next cycle. start with N=11 is ignored; stay in IDLE.
//   N is sampled only at start. Changes to N during a game are ignored.
//   WAIT_FLIP: flip_valid&flip_match -> ADVANCE; flip_valid&!flip_match -> STROBE.
//   flip_valid in any state other than WAIT_FLIP is dropped; it is not queued.
//   ADVANCE (1 cycle): if turn > n_code+1 (out of range) -> STROBE, no move.
//     Otherwise pos[turn] += 1. Reaching WIN_POS -> DONE with winner<=turn and
//     game_over<=1 on the same edge. Else -> WAIT_FLIP (same player flips again).
//   Positions never exceed WIN_POS; no wrap-around.
//   STROBE: strobe=1 for exactly STROBE_CYC cycles (counter), then -> SETTLE.
//   SETTLE: strobe=0 for SETTLE_CYC cycles; on the last cycle cur_player<=turn,
//     then -> WAIT_FLIP.
//   Turn-change latency: mismatch flip to ready = STROBE_CYC+SETTLE_CYC+1 cycles.
//   DONE: positions, winner and game_over held; flips ignored. start (N!=11)
//     restarts as from IDLE: clear pos, game_over<=0, winner<=0.
//   start in WAIT_FLIP/ADVANCE/STROBE/SETTLE is ignored.
//   Only next_turn's shared rst resets the turn index. start does not reset it:
//     the first player of a new game is the current turn value.
//   The strobe is glitch-free (registered output) because next_turn clocks on it.
// TESTING
//   rst, N=00, start, 3 match flips on turn=0 -> p0=3, cur_player=0, no strobe pulse
//   mismatch flip, STROBE_CYC=2 -> strobe high exactly 2 cycles, next_turn moves
//     turn 0->1, cur_player=1 and ready=1 four cycles after flip_valid
//   N=10, 4 mismatches -> cur_player sequence 1,2,3,0; pos_all unchanged
//   p1 at 22 (WIN_POS=23), match on turn=1 -> game_over=1, winner=1, p1=23;
//     further flips leave all outputs unchanged; start clears pos, game_over=0
//   N=11 start -> stays IDLE, ready=0; flip_valid during STROBE dropped; rst
//     asserted mid-STROBE -> strobe 0 immediately, all outputs 0, state IDLE

Source files
------------

// File: rtl/turn_sequencer.sv
// Turn sequencer: game-flow controller between the tile-flip logic and next_turn.
// A matching flip moves the current player's chicken one step; a mismatching flip
// (or a match on a player index outside the active range) ends the turn with a
// registered strobe into next_turn, after which the new turn index is captured.
// Reaching WIN_POS ends the game and holds positions, winner and game_over.
module turn_sequencer #(
    parameter int POS_W      = 5,
    parameter int WIN_POS    = 23,
    parameter int STROBE_CYC = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         N,
    input  logic [1:0]         turn,
    input  logic               flip_valid,
    input  logic               flip_match,
    output logic               next_turn_strobe,
    output logic [4*POS_W-1:0] pos_all,
    output logic [1:0]         cur_player,
    output logic               ready,
    output logic               game_over,
    output logic [1:0]         winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FLIP,
        S_ADVANCE,
        S_STROBE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam int CNT_MAX = (STROBE_CYC > SETTLE_CYC) ? STROBE_CYC : SETTLE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [POS_W-1:0] WIN_P       = POS_W'(WIN_POS);

    state_t                  state;
    logic [1:0]              n_code;
    logic [3:0][POS_W-1:0]   pos;
    logic [CNT_W-1:0]        cnt;

    logic                    start_ok;
    logic                    turn_out_of_range;
    logic [POS_W-1:0]        pos_next;

    assign pos_all           = pos;
    assign start_ok          = start && (N != 2'b11);
    // n_code encodes (players - 2), so the highest legal index is n_code + 1
    assign turn_out_of_range = ({1'b0, turn} > ({1'b0, n_code} + 3'd1));
    assign pos_next          = pos[turn] + POS_W'(1);

    // Game-flow FSM; every output is a register so the strobe into next_turn is glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            n_code           <= 2'b00;
            pos              <= '0;
            cnt              <= '0;
            next_turn_strobe <= 1'b0;
            cur_player       <= 2'b00;
            ready            <= 1'b0;
            game_over        <= 1'b0;
            winner           <= 2'b00;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        n_code     <= N;
                        pos        <= '0;
                        cur_player <= turn;
                        game_over  <= 1'b0;
                        winner     <= 2'b00;
                        ready      <= 1'b1;
                        state      <= S_WAIT_FLIP;
                    end
                end
                S_WAIT_FLIP: begin
                    if (flip_valid) begin
                        ready <= 1'b0;
                        if (flip_match) begin
                            state <= S_ADVANCE;
                        end else begin
                            next_turn_strobe <= 1'b1;
                            cnt              <= STROBE_LOAD;
                            state            <= S_STROBE;
                        end
                    end
                end
                S_ADVANCE: begin
                    if (turn_out_of_range) begin
                        next_turn_strobe <= 1'b1;
                        cnt              <= STROBE_LOAD;
                        state            <= S_STROBE;
                    end else begin
                        pos[turn] <= pos_next;
                        if (pos_next == WIN_P) begin
                            winner    <= turn;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            ready <= 1'b1;
                            state <= S_WAIT_FLIP;
                        end
                    end
                end
                S_STROBE: begin
                    if (cnt == '0) begin
                        next_turn_strobe <= 1'b0;
                        cnt              <= SETTLE_LOAD;
                        state            <= S_SETTLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        cur_player <= turn;
                        ready      <= 1'b1;
                        state      <= S_WAIT_FLIP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
